// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : AXI4 read-side bridge. Arbitrates NUM_MST SRAM-like read masters
//            onto one AR/R channel pair, with up to OUTSTANDING in-flight reads
//            per master. The AXI ID carries the master index, and R beats are
//            routed back to the master by ID.
// Options  : AXI_RD_FIXED_PRIO_EN - fixed priority, highest index wins
//            (default: round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_arbiter #(
    parameter int NUM_MST     = 2,
    parameter int OUTSTANDING = 2,
    parameter int ID_W        = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NUM_MST-1:0]    m_req,
    input  logic [NUM_MST*32-1:0] m_addr,
    input  logic [NUM_MST*2-1:0]  m_size,
    output logic [NUM_MST-1:0]    m_addr_ok,
    output logic [NUM_MST-1:0]    m_data_ok,
    output logic [31:0]           m_rdata,
    output logic [ID_W-1:0]       arid,
    output logic [31:0]           araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [31:0]           rdata,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int c_PTR_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int c_CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [ID_W:0] c_NUM_MST_ID = (ID_W + 1)'(NUM_MST);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0]   r_cnt [NUM_MST];
    logic [ID_W-1:0]      r_arid;
    logic [31:0]          r_araddr;
    logic [2:0]           r_arsize;
    logic [NUM_MST-1:0]   r_data_ok;
    logic [31:0]          r_rdata;

    logic [NUM_MST-1:0]   w_elig;
    logic [NUM_MST-1:0]   w_gnt_oh;
    logic [NUM_MST-1:0]   w_rid_oh;
    logic [NUM_MST-1:0]   w_dec;
    logic [c_PTR_W-1:0]   w_gnt;
    logic                 w_found;
    logic                 w_grant;
    logic                 w_r_fire;
    logic                 w_rid_ok;
    logic [31:0]          w_sel_addr;
    logic [1:0]           w_sel_size;

    assign w_r_fire = rvalid && rready;
    assign w_rid_ok = ({1'b0, rid} < c_NUM_MST_ID);
    // The AR slot only takes a new grant while empty, so at most one issue per two cycles.
    assign w_grant  = (r_state == ST_IDLE) && w_found;

    // Per-master eligibility, grant/ID decode and R-beat credit return.
    for (genvar i = 0; i < NUM_MST; i++) begin : g_mst
        assign w_elig[i]   = m_req[i] && (r_cnt[i] < c_CNT_W'(OUTSTANDING));
        assign w_gnt_oh[i] = (w_gnt == c_PTR_W'(i));
        assign w_rid_oh[i] = (rid == ID_W'(i));
        // A stray return for an idle master must not wrap its counter.
        assign w_dec[i]    = w_r_fire && w_rid_ok && rlast && w_rid_oh[i]
                             && (r_cnt[i] != '0);
    end

    // Pick the winning master among the eligible ones.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
`ifdef AXI_RD_FIXED_PRIO_EN
        // Ascending scan: the last eligible index seen (highest) wins.
        for (int i = 0; i < NUM_MST; i++) begin
            if (w_elig[i]) begin
                w_found = 1'b1;
                w_gnt   = c_PTR_W'(i);
            end
        end
`else
        // Descending offsets from ptr: the smallest offset assigned last wins.
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (w_elig[i] && ((i == int'(r_ptr) + k) ||
                                  (i + NUM_MST == int'(r_ptr) + k))) begin
                    w_found = 1'b1;
                    w_gnt   = c_PTR_W'(i);
                end
            end
        end
`endif
    end

    // Address/size mux for the granted master.
    always_comb begin
        w_sel_addr = '0;
        w_sel_size = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_addr = m_addr[32*i +: 32];
                w_sel_size = m_size[2*i +: 2];
            end
        end
    end

    // AR slot next state: fill on grant, empty on handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nxt = ST_BUSY;
            ST_BUSY: if (arready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // AR slot state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // AR fields are captured on grant and held stable while BUSY.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_arid   <= '0;
            r_araddr <= '0;
            r_arsize <= '0;
        end else if (w_grant) begin
            r_arid   <= ID_W'(w_gnt);
            r_araddr <= w_sel_addr;
            r_arsize <= {1'b0, w_sel_size};
        end
    end

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ptr <= '0;
        end else begin
`ifdef AXI_RD_FIXED_PRIO_EN
            r_ptr <= '0;
`else
            if (w_grant) begin
                r_ptr <= (w_gnt == c_PTR_W'(NUM_MST - 1)) ? '0 : w_gnt + c_PTR_W'(1);
            end
`endif
        end
    end

    // Outstanding-read counters; simultaneous issue and return cancel out.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_MST; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (m_addr_ok[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
                else if (!m_addr_ok[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - c_CNT_W'(1);
            end
        end
    end

    // R beats are registered and steered to their master by ID.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_data_ok <= '0;
            r_rdata   <= '0;
        end else begin
            r_data_ok <= (w_r_fire && w_rid_ok) ? w_rid_oh : '0;
            if (w_r_fire && w_rid_ok) r_rdata <= rdata;
        end
    end

    assign m_addr_ok = (w_grant && !areset) ? w_gnt_oh : '0;
    assign m_data_ok = r_data_ok;
    assign m_rdata   = r_rdata;
    assign arid      = r_arid;
    assign araddr    = r_araddr;
    assign arsize    = r_arsize;
    assign arvalid   = (r_state == ST_BUSY);
    assign rready    = !areset;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Brief    : Scoreboard bench for axi_rd_arbiter. Stimulus pushes expected
//            grants, AR beats and data returns; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

    localparam int NUM_MST     = 2;
    localparam int OUTSTANDING = 2;
    localparam int ID_W        = 4;

    logic                  aclk = 1'b0;
    logic                  areset = 1'b1;
    logic [NUM_MST-1:0]    m_req = '0;
    logic [NUM_MST*32-1:0] m_addr = '0;
    logic [NUM_MST*2-1:0]  m_size = '0;
    logic [NUM_MST-1:0]    m_addr_ok;
    logic [NUM_MST-1:0]    m_data_ok;
    logic [31:0]           m_rdata;
    logic [ID_W-1:0]       arid;
    logic [31:0]           araddr;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready = 1'b0;
    logic [ID_W-1:0]       rid = '0;
    logic [31:0]           rdata = '0;
    logic                  rlast = 1'b0;
    logic                  rvalid = 1'b0;
    logic                  rready;

    int checks = 0;
    int errors = 0;

    int                    q_gnt [$];
    logic [ID_W+34:0]      q_ar  [$];
    logic [NUM_MST+31:0]   q_r   [$];

    axi_rd_arbiter #(
        .NUM_MST     (NUM_MST),
        .OUTSTANDING (OUTSTANDING),
        .ID_W        (ID_W)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_size    (m_size),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .arid      (arid),
        .araddr    (araddr),
        .arsize    (arsize),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the expected grant and AR beat for master idx using its current request.
    task automatic expect_gnt(input int idx);
        q_gnt.push_back(idx);
        q_ar.push_back({ID_W'(idx), m_addr[32*idx +: 32], 1'b0, m_size[2*idx +: 2]});
    endtask

    // Present one R beat for a cycle; queue its expected data_ok if the ID is valid.
    task automatic beat(input int id, input logic [31:0] data);
        logic [NUM_MST-1:0] oh;
        oh = '0;
        if (id < NUM_MST) begin
            oh[id] = 1'b1;
            q_r.push_back({oh, data});
        end
        rid    = ID_W'(id);
        rdata  = data;
        rlast  = 1'b1;
        rvalid = 1'b1;
        @(posedge aclk); #1;
    endtask

    // Hold one request until accepted, bounded.
    task automatic req_one(input int idx);
        bit got;
        got = 1'b0;
        m_req[idx] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge aclk);
            if (m_addr_ok[idx]) got = 1'b1;
            @(posedge aclk); #1;
        end
        m_req[idx] = 1'b0;
        chk("req_granted", 64'(got), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        areset = 1'b1;
        m_req  = '0;
        rvalid = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_addr_ok != '0) begin
                if (q_gnt.size() == 0) chk("unexpected_addr_ok", 64'(m_addr_ok), 64'd0);
                else chk("addr_ok", 64'(m_addr_ok), 64'd1 << q_gnt.pop_front());
            end
            if (arvalid && arready) begin
                if (q_ar.size() == 0) chk("unexpected_ar", 64'(arid), 64'hFFFF);
                else chk("ar_beat", 64'({arid, araddr, arsize}), 64'(q_ar.pop_front()));
            end
            if (m_data_ok != '0) begin
                if (q_r.size() == 0) chk("unexpected_data_ok", 64'(m_data_ok), 64'd0);
                else chk("data_ok", 64'({m_data_ok, m_rdata}), 64'(q_r.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [4];

        // Reset hold with active requests and an R beat pending.
        m_req  = 2'b11;
        rvalid = 1'b1;
        rlast  = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("rst_arvalid", 64'(arvalid), 64'd0);
            chk("rst_rready", 64'(rready), 64'd0);
            chk("rst_addr_ok", 64'(m_addr_ok), 64'd0);
            chk("rst_data_ok", 64'(m_data_ok), 64'd0);
            chk("rst_ar_fields", 64'({arid, araddr, arsize}), 64'd0);
            chk("rst_rdata", 64'(m_rdata), 64'd0);
        end
        @(posedge aclk); #1;
        areset  = 1'b0;
        m_req   = '0;
        rvalid  = 1'b0;
        arready = 1'b1;
        @(negedge aclk);
        chk("rready_out_of_reset", 64'(rready), 64'd1);
        @(posedge aclk); #1;

        // Single read from master 0.
        m_addr[31:0] = 32'h1C00_0000;
        m_size[1:0]  = 2'd2;
        expect_gnt(0);
        req_one(0);
        @(negedge aclk);
        chk("arvalid_after_grant", 64'(arvalid), 64'd1);
        @(posedge aclk); #1;
        beat(0, 32'hDEAD_BEEF);
        rvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Arbitration with both masters requesting and no returns.
        do_reset();
        m_addr = {32'h0000_0200, 32'h0000_0100};
        m_size = {2'd1, 2'd2};
`ifdef AXI_RD_FIXED_PRIO_EN
        order = '{1, 1, 0, 0};
`else
        order = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) expect_gnt(order[i]);
        m_req = 2'b11;
        repeat (10) @(posedge aclk);
        #1;
        // One credit back for master 1: it is granted again.
        expect_gnt(1);
        beat(1, 32'hAAAA_0001);
        rvalid = 1'b0;
        @(posedge aclk); #1;
        m_req = '0;
        @(posedge aclk); #1;
        // Drain both masters with back-to-back beats.
        beat(0, 32'hAAAA_0002);
        beat(0, 32'hAAAA_0003);
        beat(1, 32'hAAAA_0004);
        beat(1, 32'hAAAA_0005);
        rvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Out-of-order return across masters.
        expect_gnt(0);
        req_one(0);
        expect_gnt(1);
        req_one(1);
        @(posedge aclk); #1;
        beat(1, 32'h2222_2222);
        beat(0, 32'h1111_1111);
        rvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Simultaneous issue and return on master 0 with one read in flight.
        expect_gnt(0);
        req_one(0);
        @(posedge aclk); #1;
        expect_gnt(0);
        m_req[0] = 1'b1;
        beat(0, 32'h3333_3333);
        m_req[0] = 1'b0;
        rvalid   = 1'b0;
        @(posedge aclk); #1;
        // Count is still 1: exactly one more grant fits.
        expect_gnt(0);
        req_one(0);
        @(posedge aclk); #1;
        // Out-of-range ID is swallowed without touching any master.
        beat(5, 32'h5555_5555);
        rvalid = 1'b0;
        // Master 0 is full: no grant expected.
        m_req[0] = 1'b1;
        repeat (6) @(posedge aclk);
        #1;
        m_req[0] = 1'b0;
        beat(0, 32'h4444_0001);
        beat(0, 32'h4444_0002);
        rvalid = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);

        chk("gnt_queue_empty", 64'(q_gnt.size()), 64'd0);
        chk("ar_queue_empty", 64'(q_ar.size()), 64'd0);
        chk("r_queue_empty", 64'(q_r.size()), 64'd0);
        chk("idle_arvalid", 64'(arvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
